ru_writeback_arbiter: RTL
=========================

# ru_writeback_arbiter

Write-side front end of the recompute-unit (RU) data buffer in the BISR recompute-unit path. It collects result words from `NUM_RU` recompute units, each with a (row, col) target. It arbitrates among them round-robin and issues at most one registered write per cycle (`we`, row, col, data) into the buffer's single write port. One holding slot per RU decouples RU handshakes from buffer write bandwidth. A `hold` input freezes writes while BIST/BISR owns the buffer.

## Interface
- `ROWS`, 4, PE array rows; row index field width is `ROWS` bits, binary-encoded.
- `COLS`, 4, PE array columns; col index field width is `COLS` bits, binary-encoded.
- `NUM_RU`, 4, number of recompute units (≥1).
- `WORD_SIZE`, 16, result word width.

Clock/reset: one clock; reset is synchronous and active-high.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous active-high reset.
- `ru_valid`  in  `NUM_RU`  RU i presents a result.
- `ru_ready`  out  `NUM_RU`  slot i can accept.
- `ru_row[0:NUM_RU-1]`  in  `ROWS` each  target row.
- `ru_col[0:NUM_RU-1]`  in  `COLS` each  target col.
- `ru_data[0:NUM_RU-1]`  in  `WORD_SIZE` each  result word.
- `hold`  in  1  no grants while high; slots retain contents.
- `we`  out  1  buffer write enable (registered).
- `wr_row`  out  `ROWS`  write row (registered).
- `wr_col`  out  `COLS`  write col (registered).
- `wr_data`  out  `WORD_SIZE`  write data (registered).
- `idx_err`  out  1  one-cycle pulse: granted entry had row ≥ ROWS or col ≥ COLS and was dropped.
- `pending`  out  `$clog2(NUM_RU+1)`  number of full slots (registered count).

## Operation
- Per RU: a slot holding {row, col, data} plus a `full` bit.
- Ready rule: `ru_ready[i] = !rst && (!full[i] || grant[i])`. The slot may be refilled on the same edge it drains.
- Accept: `ru_valid[i] && ru_ready[i]` at an edge captures the inputs and sets `full[i]`.
- Arbitration is combinational from `full` and `ptr`. When `hold` is low and any slot is full, the first full slot at or after `ptr` (modulo `NUM_RU`) is granted. On a grant, `ptr` ← granted index + 1, wrapping to 0 after `NUM_RU-1`.
- Granted slot clears unless refilled on the same edge.
- If the granted entry's indices are in range: `we`=1 and `wr_*` = slot contents on the next cycle.
- If the granted entry's indices are out of range: `we`=0, `idx_err`=1 for one cycle, and the entry is discarded.
- No grant (empty or `hold`): `we`=0, `idx_err`=0; `wr_*` hold their last values.
- Per-RU order is preserved. Writes from different RUs to the same cell are not merged: the later grant overwrites.
- `pending` equals the popcount of `full`, updated each edge.
- Reset values: all `full`=0, `ptr`=0, `we`=0, `wr_row`=`wr_col`=`wr_data`=0, `idx_err`=0, `pending`=0. `ru_ready`=0 while `rst` is high.
- Reset mid-operation discards all slot contents. Accepted but unwritten results are lost; recompute control must reissue them.

## Timing
- Latency: an accept at edge N makes the slot full in cycle N+1. An uncontended grant occurs at edge N+1, so `we` is high during cycle N+2.
- Throughput: one write per cycle aggregate. A single RU streaming alone sustains one result per cycle.
- `hold` sampled high at edge E: no grant at E. Accepts continue while slots are free. Deassertion allows a grant at the next edge.
- With all slots full and `hold` high, `ru_ready`=0 for every RU.

## Structure
- Shared package `bisr_ru_pkg`: `ru_entry_t` struct {row, col, data}, plus the `NUM_RU`/`ROWS`/`COLS`/`WORD_SIZE` defaults used by the buffer and this block.
- Sub-module `rr_arbiter` (parameter N; inputs `req[N]`, `ptr`, `en`; outputs one-hot `grant` and `grant_idx`) is purely combinational. `ptr` lives in the parent.

## Test plan
- Single RU: RU1 sends (row 2, col 3, 0xBEEF) at edge 5 → `we`=1, `wr_row`=2, `wr_col`=3, `wr_data`=0xBEEF in cycle 7. `pending` is 1 in cycle 6 only.
- Fairness: all 4 RUs valid simultaneously with data 0x10..0x13 and `ptr`=0 → four consecutive writes in order 0x10, 0x11, 0x12, 0x13; `ptr` returns to 0.
- Back-pressure: `hold`=1, and each RU sends twice → second beat stalls (`ru_ready`=0 for all, `pending`=4). Release `hold` → 8 writes over 8 cycles, per-RU order kept.
- Out of range: ROWS=4, RU0 sends row 5 → `idx_err` pulses once, `we` stays 0, and the slot frees.
- Reset mid-stream: `rst` asserted with 3 slots full → the next cycle has `pending`=0, `we`=0, all outputs zero, and no stale writes after `rst` drops.
- Streaming: RU2 alone, valid every cycle for 16 cycles → 16 writes, one per cycle, with `ru_ready[2]` constantly 1.

Source files
------------

// File: rtl/bisr_ru_pkg.sv
// ============================================================================
// Module   : bisr_ru_pkg
// Brief    : Shared types and default geometry for the BISR recompute-unit path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bisr_ru_pkg;

    localparam int C_ROWS      = 4;
    localparam int C_COLS      = 4;
    localparam int C_NUM_RU    = 4;
    localparam int C_WORD_SIZE = 16;

    typedef struct packed {
        logic [C_ROWS-1:0]      row;
        logic [C_COLS-1:0]      col;
        logic [C_WORD_SIZE-1:0] data;
    } ru_entry_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin picker; the rotating pointer is owned by the caller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx
);

    logic             w_found;
    logic [PTR_W-1:0] w_sel;

    // Scan N positions starting at ptr; the first requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_sel     = '0;
        for (int k = 0; k < N; k++) begin
            w_sel = PTR_W'((int'(ptr) + k) % N);
            if (en && !w_found && req[w_sel]) begin
                w_found      = 1'b1;
                grant[w_sel] = 1'b1;
                grant_idx    = w_sel;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ru_writeback_arbiter.sv
// ============================================================================
// Module   : ru_writeback_arbiter
// Brief    : Per-RU holding slots feeding the RU data buffer's single write port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ru_writeback_arbiter
    import bisr_ru_pkg::*;
#(
    parameter int ROWS      = C_ROWS,
    parameter int COLS      = C_COLS,
    parameter int NUM_RU    = C_NUM_RU,
    parameter int WORD_SIZE = C_WORD_SIZE
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RU-1:0]            ru_valid,
    output logic [NUM_RU-1:0]            ru_ready,
    input  logic [ROWS-1:0]              ru_row  [NUM_RU],
    input  logic [COLS-1:0]              ru_col  [NUM_RU],
    input  logic [WORD_SIZE-1:0]         ru_data [NUM_RU],
    input  logic                         hold,
    output logic                         we,
    output logic [ROWS-1:0]              wr_row,
    output logic [COLS-1:0]              wr_col,
    output logic [WORD_SIZE-1:0]         wr_data,
    output logic                         idx_err,
    output logic [$clog2(NUM_RU+1)-1:0]  pending
);

    localparam int PTR_W = (NUM_RU > 1) ? $clog2(NUM_RU) : 1;
    localparam int CNT_W = $clog2(NUM_RU + 1);

    typedef struct packed {
        logic [ROWS-1:0]      row;
        logic [COLS-1:0]      col;
        logic [WORD_SIZE-1:0] data;
    } slot_t;

    slot_t                slot_q [NUM_RU];
    slot_t                slot_d [NUM_RU];
    logic [NUM_RU-1:0]    full_q, full_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic                 we_q, we_d;
    logic                 idx_err_q, idx_err_d;
    logic [ROWS-1:0]      wr_row_q, wr_row_d;
    logic [COLS-1:0]      wr_col_q, wr_col_d;
    logic [WORD_SIZE-1:0] wr_data_q, wr_data_d;
    logic [CNT_W-1:0]     pending_q, pending_d;

    logic [NUM_RU-1:0]    w_grant;
    logic [NUM_RU-1:0]    w_accept;
    logic [PTR_W-1:0]     w_grant_idx;
    logic                 w_any_grant;
    logic                 w_in_range;
    slot_t                w_head;

    function automatic logic [CNT_W-1:0] popcnt(input logic [NUM_RU-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_RU; i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
        return cnt;
    endfunction

    rr_arbiter #(
        .N     (NUM_RU),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req       (full_q),
        .ptr       (ptr_q),
        .en        (!hold),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    // A draining slot is ready again on the same edge, giving one beat per cycle per RU.
    assign ru_ready    = ~{NUM_RU{rst}} & (~full_q | w_grant);
    assign w_accept    = ru_valid & ru_ready;
    assign w_any_grant = |w_grant;
    assign w_head      = slot_q[w_grant_idx];
    assign w_in_range  = (int'(w_head.row) < ROWS) && (int'(w_head.col) < COLS);

    always_comb begin
        full_d    = full_q;
        ptr_d     = ptr_q;
        we_d      = 1'b0;
        idx_err_d = 1'b0;
        wr_row_d  = wr_row_q;
        wr_col_d  = wr_col_q;
        wr_data_d = wr_data_q;
        for (int i = 0; i < NUM_RU; i++) begin
            slot_d[i] = slot_q[i];
            if (w_grant[i]) begin
                full_d[i] = 1'b0;
            end
            if (w_accept[i]) begin
                full_d[i] = 1'b1;
                slot_d[i] = '{row: ru_row[i], col: ru_col[i], data: ru_data[i]};
            end
        end
        if (w_any_grant) begin
            ptr_d = (w_grant_idx == PTR_W'(NUM_RU - 1)) ? '0 : w_grant_idx + PTR_W'(1);
            if (w_in_range) begin
                we_d      = 1'b1;
                wr_row_d  = w_head.row;
                wr_col_d  = w_head.col;
                wr_data_d = w_head.data;
            end else begin
                idx_err_d = 1'b1;
            end
        end
        pending_d = popcnt(full_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q    <= '0;
            ptr_q     <= '0;
            we_q      <= 1'b0;
            idx_err_q <= 1'b0;
            wr_row_q  <= '0;
            wr_col_q  <= '0;
            wr_data_q <= '0;
            pending_q <= '0;
            for (int i = 0; i < NUM_RU; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            full_q    <= full_d;
            ptr_q     <= ptr_d;
            we_q      <= we_d;
            idx_err_q <= idx_err_d;
            wr_row_q  <= wr_row_d;
            wr_col_q  <= wr_col_d;
            wr_data_q <= wr_data_d;
            pending_q <= pending_d;
            for (int i = 0; i < NUM_RU; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    assign we      = we_q;
    assign idx_err = idx_err_q;
    assign wr_row  = wr_row_q;
    assign wr_col  = wr_col_q;
    assign wr_data = wr_data_q;
    assign pending = pending_q;

endmodule

`default_nettype wire
